pong_ball_ctrl: RTL and testbench



---
 rtl/pong_ball_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: per-frame ball motion, wall/paddle bounces, scoring and the
// serve / play / pause / game-over sequence for the pong pixel pipeline.
// Optional build macro PONG_SPEEDUP_EN: ball speeds up by one pixel per
// paddle hit (capped at twice the base speed) and resets on each serve.
module pong_ball_ctrl #(
  parameter int H_VALID      = 640,
  parameter int V_VALID      = 480,
  parameter int BALL_SIZE    = 16,
  parameter int SPEED        = 4,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] pad_l_y,
  input  logic [9:0] pad_r_y,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit,
  output logic       point,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Centre position and clamp positions in output coordinates
  localparam logic [9:0] CX     = 10'((H_VALID - BALL_SIZE) / 2);
  localparam logic [9:0] CY     = 10'((V_VALID - BALL_SIZE) / 2);
  localparam logic [9:0] X_MAX  = 10'(H_VALID - BALL_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(V_VALID - BALL_SIZE);
  localparam logic [9:0] X_RHIT = 10'(PAD_R_X - BALL_SIZE);
  localparam logic [9:0] X_LHIT = 10'(PAD_L_X + PAD_W);
  localparam logic [9:0] LAST_X = 10'(H_VALID - 1);
  localparam logic [9:0] LAST_Y = 10'(V_VALID - 1);

  // Signed 12-bit constants so paddle sums near 1023 cannot overflow
  localparam logic signed [11:0] HV_S  = 12'(H_VALID);
  localparam logic signed [11:0] VV_S  = 12'(V_VALID);
  localparam logic signed [11:0] BS_S  = 12'(BALL_SIZE);
  localparam logic signed [11:0] PH_S  = 12'(PAD_H);
  localparam logic signed [11:0] PRX_S = 12'(PAD_R_X);
  localparam logic signed [11:0] PLF_S = 12'(PAD_L_X + PAD_W);

  localparam logic [3:0] WIN_S      = 4'(WIN_SCORE);
  localparam logic [3:0] SPD_INIT   = 4'(SPEED);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  state_t     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       hit_q, hit_d;
  logic       point_q, point_d;
  logic       game_over_q, game_over_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;
  logic       frame_tick_q, frame_tick_d;

  logic [3:0] speed_cur;

`ifdef PONG_SPEEDUP_EN
  localparam logic [3:0] SPD_MAX = 4'(2 * SPEED);
  logic [3:0] spd_q, spd_d;
  assign speed_cur = spd_q;

  // Speed steps up on each paddle hit and drops back to base on every serve entry
  always_comb begin
    if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
      spd_d = SPD_INIT;
    end else if (hit_d && (spd_q < SPD_MAX)) begin
      spd_d = spd_q + 4'd1;
    end else begin
      spd_d = spd_q;
    end
  end

  // Speed register
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      spd_q <= SPD_INIT;
    end else begin
      spd_q <= spd_d;
    end
  end
`else
  assign speed_cur = SPD_INIT;
`endif

  // Signed working copies; next positions never wrap below zero
  logic signed [11:0] bx, by, sp, nx, ny, pl_y, pr_y;
  logic               ovl_l, ovl_r;

  assign bx    = $signed({2'b00, ball_x_q});
  assign by    = $signed({2'b00, ball_y_q});
  assign sp    = $signed({8'd0, speed_cur});
  assign pl_y  = $signed({2'b00, pad_l_y});
  assign pr_y  = $signed({2'b00, pad_r_y});
  assign nx    = dx_q ? (bx + sp) : (bx - sp);
  assign ny    = dy_q ? (by + sp) : (by - sp);
  // Paddle overlap judged on the ball row before this frame's move
  assign ovl_l = ((by + BS_S) > pl_y) && (by < (pl_y + PH_S));
  assign ovl_r = ((by + BS_S) > pr_y) && (by < (pr_y + PH_S));

  // Frame tick: one cycle after the last active pixel is seen
  assign frame_tick_d = (pix_x == LAST_X) && (pix_y == LAST_Y);

  // Next-state: game sequencing plus ball motion on frame ticks
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    pause_cnt_d = pause_cnt_q;
    hit_d       = 1'b0;
    point_d     = 1'b0;
    case (state_q)
      ST_SERVE: begin
        if (serve) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (frame_tick_q) begin
          if (dy_q && ((ny + BS_S) >= VV_S)) begin
            ball_y_d = Y_MAX;
            dy_d     = 1'b0;
          end else if (!dy_q && (ny <= 12'sd0)) begin
            ball_y_d = 10'd0;
            dy_d     = 1'b1;
          end else begin
            ball_y_d = ny[9:0];
          end
          if (dx_q) begin
            if (((bx + BS_S) <= PRX_S) && ((nx + BS_S) > PRX_S) && ovl_r) begin
              ball_x_d = X_RHIT;
              dx_d     = 1'b0;
              hit_d    = 1'b1;
            end else if ((nx + BS_S) >= HV_S) begin
              ball_x_d = X_MAX;
              dx_d     = 1'b0;
              point_d  = 1'b1;
              if (score_l_q < WIN_S) begin
                score_l_d = score_l_q + 4'd1;
              end else begin
                score_l_d = score_l_q;
              end
            end else begin
              ball_x_d = nx[9:0];
            end
          end else begin
            if ((bx >= PLF_S) && (nx < PLF_S) && ovl_l) begin
              ball_x_d = X_LHIT;
              dx_d     = 1'b1;
              hit_d    = 1'b1;
            end else if (nx <= 12'sd0) begin
              ball_x_d = 10'd0;
              dx_d     = 1'b1;
              point_d  = 1'b1;
              if (score_r_q < WIN_S) begin
                score_r_d = score_r_q + 4'd1;
              end else begin
                score_r_d = score_r_q;
              end
            end else begin
              ball_x_d = nx[9:0];
            end
          end
          if (point_d) begin
            pause_cnt_d = 8'd0;
            if ((score_l_d == WIN_S) || (score_r_d == WIN_S)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_PAUSE;
            end
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (frame_tick_q) begin
          if (pause_cnt_q == PAUSE_LAST) begin
            ball_x_d    = CX;
            ball_y_d    = CY;
            pause_cnt_d = 8'd0;
            state_d     = ST_SERVE;
          end else begin
            pause_cnt_d = pause_cnt_q + 8'd1;
            state_d     = ST_PAUSE;
          end
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (serve) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          ball_x_d  = CX;
          ball_y_d  = CY;
          dx_d      = 1'b1;
          dy_d      = 1'b1;
          state_d   = ST_SERVE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  // State, ball and score registers with asynchronous reset to the serve position
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_SERVE;
      ball_x_q     <= CX;
      ball_y_q     <= CY;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      hit_q        <= 1'b0;
      point_q      <= 1'b0;
      game_over_q  <= 1'b0;
      pause_cnt_q  <= 8'd0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      hit_q        <= hit_d;
      point_q      <= point_d;
      game_over_q  <= game_over_d;
      pause_cnt_q  <= pause_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign hit       = hit_q;
  assign point     = point_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed and randomized checks of pong_ball_ctrl against
// an integer-arithmetic model of the game rules. Frames are compressed: a few
// active pixels, the last active pixel, then blanking.
`timescale 1ns/1ps
module tb_pong_ball_ctrl;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam int SPEED   = 4;
`ifdef PONG_SPEEDUP_EN
  localparam int SPD_AFTER_HIT = SPEED + 1;
`else
  localparam int SPD_AFTER_HIT = SPEED;
`endif

  logic       vga_clk = 1'b0;
  logic       sys_rst_n;
  logic [9:0] pix_x, pix_y, pad_l_y, pad_r_y;
  logic       serve;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       hit, point, game_over;

  int checks   = 0;
  int failures = 0;

  // Model: position, velocity sign, scores, speed, phase (0 wait serve,
  // 1 moving, 2 frozen after a point, 3 finished), frozen-frame count
  int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_spd, m_phase, m_wait, m_hit, m_point;
  logic last_hit, last_point;

  always #5 vga_clk = ~vga_clk;

  pong_ball_ctrl dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pad_l_y   (pad_l_y),
    .pad_r_y   (pad_r_y),
    .serve     (serve),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score_l   (score_l),
    .score_r   (score_r),
    .hit       (hit),
    .point     (point),
    .game_over (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = (H_VALID - 16) / 2; m_y = (V_VALID - 16) / 2;
    m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_spd = SPEED;
    m_phase = 0; m_wait = 0; m_hit = 0; m_point = 0;
  endtask

  task automatic model_serve();
    m_hit = 0; m_point = 0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 3) begin
      m_sl = 0; m_sr = 0; m_x = 312; m_y = 232; m_dx = 1; m_dy = 1;
      m_phase = 0; m_spd = SPEED;
    end
  endtask

  task automatic model_tick();
    int nx, ny, pl, pr;
    bit ovl_l, ovl_r;
    m_hit = 0; m_point = 0;
    if (m_phase == 1) begin
      nx = m_x + m_dx * m_spd;
      ny = m_y + m_dy * m_spd;
      pl = int'(pad_l_y); pr = int'(pad_r_y);
      ovl_l = (m_y + 16 > pl) && (m_y < pl + 64);
      ovl_r = (m_y + 16 > pr) && (m_y < pr + 64);
      if (m_dx > 0) begin
        if (m_x + 16 <= 616 && nx + 16 > 616 && ovl_r) begin
          m_x = 600; m_dx = -1; m_hit = 1;
        end else if (nx + 16 >= 640) begin
          m_x = 624; m_dx = -1; m_point = 1; m_sl = (m_sl < 9) ? m_sl + 1 : 9;
        end else m_x = nx;
      end else begin
        if (m_x >= 24 && nx < 24 && ovl_l) begin
          m_x = 24; m_dx = 1; m_hit = 1;
        end else if (nx <= 0) begin
          m_x = 0; m_dx = 1; m_point = 1; m_sr = (m_sr < 9) ? m_sr + 1 : 9;
        end else m_x = nx;
      end
      if (m_dy > 0 && ny + 16 >= 480) begin
        m_y = 464; m_dy = -1;
      end else if (m_dy < 0 && ny <= 0) begin
        m_y = 0; m_dy = 1;
      end else m_y = ny;
`ifdef PONG_SPEEDUP_EN
      if (m_hit == 1 && m_spd < 2 * SPEED) m_spd = m_spd + 1;
`endif
      if (m_point == 1) begin
        m_phase = (m_sl == 9 || m_sr == 9) ? 3 : 2;
        m_wait = 0;
      end
    end else if (m_phase == 2) begin
      m_wait++;
      if (m_wait == 60) begin
        m_x = 312; m_y = 232; m_phase = 0; m_spd = SPEED;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ball_x"}, 32'(ball_x), m_x);
    chk({tag, "_ball_y"}, 32'(ball_y), m_y);
    chk({tag, "_score_l"}, 32'(score_l), m_sl);
    chk({tag, "_score_r"}, 32'(score_r), m_sr);
    chk({tag, "_hit"}, 32'(hit), m_hit);
    chk({tag, "_point"}, 32'(point), m_point);
    chk({tag, "_game_over"}, 32'(game_over), (m_phase == 3) ? 1 : 0);
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_ball_x"}, 32'(ball_x), m_x);
    chk({tag, "_ball_y"}, 32'(ball_y), m_y);
    chk({tag, "_hit"}, 32'(hit), 0);
    chk({tag, "_point"}, 32'(point), 0);
  endtask

  task automatic frame();
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      check_hold("active");
      pix_x = 10'($urandom_range(0, H_VALID - 2));
      pix_y = 10'($urandom_range(0, V_VALID - 1));
    end
    @(negedge vga_clk);
    check_hold("active");
    pix_x = 10'(H_VALID - 1); pix_y = 10'(V_VALID - 1);
    @(negedge vga_clk);
    check_hold("tick_latency");
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    @(negedge vga_clk);
    model_tick();
    last_hit = hit; last_point = point;
    check_all("tick");
    @(negedge vga_clk);
    chk("hit_one_cycle", 32'(hit), 0);
    chk("point_one_cycle", 32'(point), 0);
  endtask

  task automatic do_serve();
    @(negedge vga_clk); serve = 1'b1;
    @(negedge vga_clk); serve = 1'b0;
    model_serve();
    check_all("serve");
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    sys_rst_n = 1'b0; serve = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
  endtask

  // Timeout guard
  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    sys_rst_n = 1'b0; serve = 1'b0;
    pix_x = 10'h3FF; pix_y = 10'h3FF; pad_l_y = 10'd0; pad_r_y = 10'd0;
    last_hit = 1'b0; last_point = 1'b0;
    model_reset();
    do_reset();

    // Idle frames without serve: ball stays centred
    repeat (5) frame();
    chk("idle_x", 32'(ball_x), 312);
    chk("idle_y", 32'(ball_y), 232);

    // Serve, first move, wall bounce, right paddle hit
    pad_r_y = 10'd380;
    do_serve();
    for (int t = 1; t <= 74; t++) begin
      frame();
      if (t == 1) begin
        chk("first_x", 32'(ball_x), 316);
        chk("first_y", 32'(ball_y), 236);
      end
      if (t == 58) chk("wall_y58", 32'(ball_y), 464);
      if (t == 59) chk("wall_y59", 32'(ball_y), 460);
      if (t == 73) begin
        chk("rhit_x73", 32'(ball_x), 600);
        chk("rhit_pulse", 32'(last_hit), 1);
      end
      if (t == 74) chk("rhit_x74", 32'(ball_x), 600 - SPD_AFTER_HIT);
    end

    // Miss on the right, pause, recentre
    do_reset();
    pad_r_y = 10'd0;
    do_serve();
    for (int t = 1; t <= 78; t++) begin
      frame();
      if (t == 73) begin
        chk("miss_nohit", 32'(last_hit), 0);
        chk("miss_x73", 32'(ball_x), 604);
      end
      if (t == 78) begin
        chk("miss_x78", 32'(ball_x), 624);
        chk("miss_score_l", 32'(score_l), 1);
        chk("miss_point", 32'(last_point), 1);
      end
    end
    for (int p = 1; p <= 60; p++) begin
      frame();
      if (p == 59) chk("pause_frozen", 32'(ball_x), 624);
      if (p == 60) begin
        chk("pause_recentre_x", 32'(ball_x), 312);
        chk("pause_recentre_y", 32'(ball_y), 232);
      end
    end
    frame();
    chk("serve_wait_x", 32'(ball_x), 312);

    // Reset in the middle of a pause
    do_reset();
    do_serve();
    repeat (88) frame();
    do_reset();

    // Nine left points end the game
    pad_r_y = 10'd960;
    for (int f = 0; f < 4000 && m_phase != 3; f++) begin
      if (m_phase == 0) do_serve();
      pad_l_y = 10'(m_y);
      frame();
    end
    chk("win_game_over", 32'(game_over), 1);
    chk("win_score_l", 32'(score_l), 9);
    chk("win_score_r", 32'(score_r), 0);
    repeat (3) frame();
    chk("over_frozen_x", 32'(ball_x), 624);
    do_serve();
    chk("over_clear_l", 32'(score_l), 0);
    chk("over_clear_go", 32'(game_over), 0);
    frame();
    chk("over_serve_x", 32'(ball_x), 312);

    // Randomized play: random/tracking paddles and stray serve pulses
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(0, 19) == 0) do_serve();
      if ($urandom_range(0, 1) == 1) begin
        v = m_y - int'($urandom_range(0, 70));
        if (v < 0) v = 0;
        pad_l_y = 10'(v);
      end else begin
        pad_l_y = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 1) == 1) begin
        v = m_y - int'($urandom_range(0, 70));
        if (v < 0) v = 0;
        pad_r_y = 10'(v);
      end else begin
        pad_r_y = 10'($urandom_range(0, 479));
      end
      frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
